// File: rtl/regbank_arbiter.sv
// Round-robin arbiter and micro-op sequencer for two clients sharing an 8-entry register bank.
// The bank has no write enable, so an idle bank is parked on a self-refresh of PARK_ADDR.
module regbank_arbiter #(
    parameter int          DATA_W    = 8,
    parameter logic [2:0]  PARK_ADDR = 3'd0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              reqA,
    input  logic              reqB,
    input  logic [1:0]        opA,
    input  logic [1:0]        opB,
    input  logic [2:0]        srcA,
    input  logic [2:0]        srcB,
    input  logic [2:0]        dstA,
    input  logic [2:0]        dstB,
    input  logic [DATA_W-1:0] wdataA,
    input  logic [DATA_W-1:0] wdataB,
    output logic              doneA,
    output logic              doneB,
    output logic [DATA_W-1:0] rdataA,
    output logic [DATA_W-1:0] rdataB,
    output logic              busy,
    output logic [2:0]        bank_en_in,
    output logic [2:0]        bank_en_out,
    output logic [DATA_W-1:0] bank_in,
    input  logic [DATA_W-1:0] bank_out
);

    typedef enum logic [1:0] {IDLE, EX1, EX2, EX3} state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_MOVE  = 2'b10;
    localparam logic [1:0] OP_SWAP  = 2'b11;

    state_t              state_reg, state_next;
    logic [1:0]          op_reg;
    logic [2:0]          src_reg, dst_reg;
    logic [DATA_W-1:0]   wdata_reg, tmp_reg;
    logic                owner_reg;        // 0 = A, 1 = B
    logic                last_reg;         // client served most recently
    logic                done_a_reg, done_b_reg;
    logic [DATA_W-1:0]   rdata_a_reg, rdata_b_reg;

    logic                elig_a, elig_b, grant_valid, grant_b;
    logic                finish, load_rdata;
    logic [DATA_W-1:0]   rdata_val;

    // A client is masked during its own done cycle so a held req is not re-granted.
    assign elig_a      = reqA & ~done_a_reg;
    assign elig_b      = reqB & ~done_b_reg;
    assign grant_valid = elig_a | elig_b;
    assign grant_b     = elig_b & (~elig_a | ~last_reg);

    always_comb begin
        state_next  = state_reg;
        bank_en_in  = PARK_ADDR;
        bank_en_out = PARK_ADDR;
        bank_in     = bank_out;
        finish      = 1'b0;
        load_rdata  = 1'b0;
        rdata_val   = bank_out;
        case (state_reg)
            IDLE: begin
                if (grant_valid) state_next = EX1;
            end
            EX1: begin
                case (op_reg)
                    OP_READ: begin
                        bank_en_out = src_reg;
                        bank_en_in  = src_reg;
                        finish      = 1'b1;
                        load_rdata  = 1'b1;
                    end
                    OP_WRITE: begin
                        bank_en_out = dst_reg;
                        bank_en_in  = dst_reg;
                        bank_in     = wdata_reg;
                        finish      = 1'b1;
                    end
                    OP_MOVE: begin
                        bank_en_out = src_reg;
                        bank_en_in  = dst_reg;
                        finish      = 1'b1;
                    end
                    OP_SWAP: begin
                        bank_en_out = src_reg;
                        bank_en_in  = src_reg;
                        state_next  = EX2;
                    end
                endcase
            end
            EX2: begin
                bank_en_out = dst_reg;
                bank_en_in  = src_reg;
                state_next  = EX3;
            end
            EX3: begin
                bank_en_out = dst_reg;
                bank_en_in  = dst_reg;
                bank_in     = tmp_reg;
                finish      = 1'b1;
                load_rdata  = 1'b1;
                rdata_val   = tmp_reg;
            end
            default: state_next = IDLE;
        endcase
        if (finish) state_next = IDLE;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg   <= IDLE;
            op_reg      <= OP_READ;
            src_reg     <= '0;
            dst_reg     <= '0;
            wdata_reg   <= '0;
            tmp_reg     <= '0;
            owner_reg   <= 1'b0;
            last_reg    <= 1'b1;
            done_a_reg  <= 1'b0;
            done_b_reg  <= 1'b0;
            rdata_a_reg <= '0;
            rdata_b_reg <= '0;
        end else begin
            state_reg  <= state_next;
            done_a_reg <= finish & ~owner_reg;
            done_b_reg <= finish & owner_reg;
            if (load_rdata) begin
                if (owner_reg) rdata_b_reg <= rdata_val;
                else           rdata_a_reg <= rdata_val;
            end
            if (state_reg == EX1 && op_reg == OP_SWAP) tmp_reg <= bank_out;
            if (state_reg == IDLE && grant_valid) begin
                op_reg    <= grant_b ? opB    : opA;
                src_reg   <= grant_b ? srcB   : srcA;
                dst_reg   <= grant_b ? dstB   : dstA;
                wdata_reg <= grant_b ? wdataB : wdataA;
                owner_reg <= grant_b;
                last_reg  <= grant_b;
            end
        end
    end

    assign doneA  = done_a_reg;
    assign doneB  = done_b_reg;
    assign rdataA = rdata_a_reg;
    assign rdataB = rdata_b_reg;
    assign busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_regbank_arbiter.sv
// Bench for regbank_arbiter: models the 8x8 bank, drives directed and random commands,
// and checks results against an array-level reference of the register contents.
module tb_regbank_arbiter;

    localparam int DW = 8;
    localparam logic [1:0] RD = 2'b00, WR = 2'b01, MV = 2'b10, SW = 2'b11;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          reqA = 0, reqB = 0;
    logic [1:0]    opA = 0, opB = 0;
    logic [2:0]    srcA = 0, srcB = 0, dstA = 0, dstB = 0;
    logic [DW-1:0] wdataA = 0, wdataB = 0;
    logic          doneA, doneB, busy;
    logic [DW-1:0] rdataA, rdataB, bank_in, bank_out;
    logic [2:0]    bank_en_in, bank_en_out;

    always #5 CLK = ~CLK;

    regbank_arbiter #(.DATA_W(DW), .PARK_ADDR(3'd0)) dut (
        .CLK(CLK), .RESET(RESET),
        .reqA(reqA), .reqB(reqB), .opA(opA), .opB(opB),
        .srcA(srcA), .srcB(srcB), .dstA(dstA), .dstB(dstB),
        .wdataA(wdataA), .wdataB(wdataB),
        .doneA(doneA), .doneB(doneB), .rdataA(rdataA), .rdataB(rdataB),
        .busy(busy), .bank_en_in(bank_en_in), .bank_en_out(bank_en_out),
        .bank_in(bank_in), .bank_out(bank_out)
    );

    // Register bank: written every clock, combinational read, cleared by reset.
    logic [DW-1:0] bank [8];
    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 8; i++) bank[i] <= '0;
        end else begin
            bank[bank_en_in] <= bank_in;
        end
    end
    assign bank_out = bank[bank_en_out];

    // Reference: register contents and last result per client.
    logic [DW-1:0] model [8];
    logic [DW-1:0] exp_rdata [2];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int c, input logic r, input logic [1:0] op,
                         input logic [2:0] src, input logic [2:0] dst, input logic [DW-1:0] wd);
        if (c == 0) begin
            reqA = r; opA = op; srcA = src; dstA = dst; wdataA = wd;
        end else begin
            reqB = r; opB = op; srcB = src; dstB = dst; wdataB = wd;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) model[i] = '0;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
    endtask

    task automatic apply_model(input int c, input logic [1:0] op,
                               input logic [2:0] src, input logic [2:0] dst, input logic [DW-1:0] wd);
        logic [DW-1:0] t;
        case (op)
            RD: exp_rdata[c] = model[src];
            WR: model[dst] = wd;
            MV: model[dst] = model[src];
            SW: begin
                t = model[src];
                exp_rdata[c] = t;
                model[src] = model[dst];
                model[dst] = t;
            end
        endcase
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        reqA = 0; reqB = 0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_doneA", doneA, 0);
        check("rst_doneB", doneB, 0);
        check("rst_rdataA", rdataA, 0);
        check("rst_rdataB", rdataB, 0);
        check("rst_en_in", bank_en_in, 0);
        check("rst_en_out", bank_en_out, 0);
        @(negedge CLK);
        RESET = 1'b0;
        model_clear();
    endtask

    task automatic check_bank();
        for (int i = 0; i < 8; i++) check($sformatf("bank_r%0d", i), bank[i], model[i]);
    endtask

    // Issue one command from one client and wait (bounded) for its done pulse.
    task automatic run_op(input int c, input logic [1:0] op, input logic [2:0] src,
                          input logic [2:0] dst, input logic [DW-1:0] wd);
        int lat, exp_lat;
        bit seen;
        @(negedge CLK);
        drive(c, 1'b1, op, src, dst, wd);
        apply_model(c, op, src, dst, wd);
        exp_lat = (op == SW) ? 4 : 2;
        seen = 0;
        lat = 0;
        while (!seen && lat < 12) begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
            if (lat == 1) check("busy_ex", busy, 1);
            if ((c == 0) ? doneA : doneB) seen = 1;
        end
        check("done_seen", seen, 1);
        check("latency", lat, exp_lat);
        check("other_done", (c == 0) ? doneB : doneA, 0);
        check("rdata", (c == 0) ? rdataA : rdataB, exp_rdata[c]);
        check("rdata_other", (c == 0) ? rdataB : rdataA, exp_rdata[1-c]);
        drive(c, 1'b0, op, src, dst, wd);
        $display("txn client=%s op=%0d src=%0d dst=%0d wdata=%h rdata=%h lat=%0d",
                 (c == 0) ? "A" : "B", op, src, dst, wd,
                 (c == 0) ? rdataA : rdataB, lat);
    endtask

    initial begin
        int cyc, k, who;
        logic [1:0] rop;

        // Write then read back through client A.
        do_reset();
        run_op(0, WR, 3'd0, 3'd3, 8'hA5);
        run_op(0, RD, 3'd3, 3'd0, 8'h00);
        check("read_r3", rdataA, 8'hA5);
        check_bank();

        // Write the park register, then stay idle.
        run_op(0, WR, 3'd0, 3'd0, 8'h3C);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            check("idle_en_in", bank_en_in, 0);
            check("idle_en_out", bank_en_out, 0);
            check("idle_busy", busy, 0);
        end
        check("park_r0", bank[0], 8'h3C);

        // SWAP by client B.
        run_op(0, WR, 3'd0, 3'd2, 8'h11);
        run_op(0, WR, 3'd0, 3'd5, 8'h22);
        run_op(1, SW, 3'd2, 3'd5, 8'h00);
        check("swap_rdataB", rdataB, 8'h11);
        check("swap_r2", bank[2], 8'h22);
        check("swap_r5", bank[5], 8'h11);
        check_bank();

        // MOVE leaves src and client rdata untouched; src==dst cases keep contents.
        run_op(0, WR, 3'd0, 3'd4, 8'h7E);
        run_op(0, MV, 3'd4, 3'd6, 8'h00);
        run_op(1, MV, 3'd5, 3'd5, 8'h00);
        run_op(0, SW, 3'd2, 3'd2, 8'h00);
        check_bank();

        // Both clients held from reset: grants alternate starting with A.
        do_reset();
        @(negedge CLK);
        drive(0, 1'b1, WR, 3'd0, 3'd1, 8'h01);
        drive(1, 1'b1, WR, 3'd0, 3'd1, 8'h02);
        cyc = 0;
        k = 0;
        while (k < 6 && cyc < 40) begin
            @(posedge CLK);
            cyc++;
            @(negedge CLK);
            check("done_excl", doneA & doneB, 0);
            if (doneA || doneB) begin
                who = doneB ? 1 : 0;
                check("grant_order", who, k % 2);
                check("grant_cycle", cyc, 2 + 2 * k);
                model[1] = (who == 0) ? 8'h01 : 8'h02;
                $display("txn client=%s op=1 dst=1 cycle=%0d", (who == 0) ? "A" : "B", cyc);
                k++;
                if (k == 6) begin
                    drive(0, 1'b0, WR, 3'd0, 3'd1, 8'h01);
                    drive(1, 1'b0, WR, 3'd0, 3'd1, 8'h02);
                end
            end
        end
        check("alt_count", k, 6);
        check("alt_r1", bank[1], 8'h02);
        check_bank();

        // Reset during EX2 of a SWAP.
        run_op(0, WR, 3'd0, 3'd2, 8'h11);
        run_op(0, WR, 3'd0, 3'd5, 8'h22);
        run_op(0, RD, 3'd5, 3'd0, 8'h00);
        @(negedge CLK);
        drive(0, 1'b1, SW, 3'd2, 3'd5, 8'h00);
        @(posedge CLK);
        @(negedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        check("pre_rst_busy", busy, 1);
        RESET = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_doneA", doneA, 0);
        check("midrst_rdataA", rdataA, 0);
        drive(0, 1'b0, SW, 3'd2, 3'd5, 8'h00);
        @(negedge CLK);
        RESET = 1'b0;
        model_clear();
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check("post_rst_no_done", doneA | doneB, 0);
            check("post_rst_busy", busy, 0);
        end
        run_op(0, WR, 3'd0, 3'd3, 8'h5A);
        run_op(1, RD, 3'd3, 3'd0, 8'h00);
        check("post_rst_read", rdataB, 8'h5A);
        check_bank();

        // Randomized single-client commands.
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            run_op(int'($urandom_range(0, 1)), rop, 3'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
        end
        check_bank();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regbank_arbiter.md
Name: regbank_arbiter

Overview:
- Two-requester round-robin arbiter and micro-op sequencer in front of the 8x8 register bank.
- The bank has a 3-bit write select, a 3-bit read select, one data input and one data output (combinational read mux). It has no write enable, so some register is written every clock.
- This block owns those four bank signals and executes READ, WRITE, MOVE and SWAP commands for two clients, such as the ALU writeback and the load path.
- When idle it parks the bank on a self-refresh (PARK_ADDR written with its own value), so no register changes.

Parameters:
DATA_W, 8, bank data width
PARK_ADDR, 3'd0, register used for idle self-refresh

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-high reset
reqA / reqB  in  1  request; held high with fields stable until done
opA / opB  in  2  00 READ, 01 WRITE, 10 MOVE, 11 SWAP
srcA / srcB  in  3  source register (READ, MOVE, SWAP)
dstA / dstB  in  3  destination register (WRITE, MOVE, SWAP)
wdataA / wdataB  in  DATA_W  write data (WRITE)
doneA / doneB  out  1  one-cycle completion pulse, registered
rdataA / rdataB  out  DATA_W  READ result or old src value for SWAP; valid with done, held until next done to that client
busy  out  1  high while state != IDLE
bank_en_in  out  3  bank write select
bank_en_out  out  3  bank read select
bank_in  out  DATA_W  bank write data
bank_out  in  DATA_W  bank read data (combinational from bank_en_out)

Behaviour:
- Decided interface: one clock, CLK; reset RESET is asynchronous and active-high.
- Reset values: state IDLE; doneA=doneB=0; rdataA=rdataB=0; tmp=0; last_served=B (so A wins first tie); busy=0.
- Reset park outputs: bank_en_in=bank_en_out=PARK_ADDR, bank_in=bank_out.
- States: IDLE, EX1, EX2, EX3.
- IDLE, outputs: park (en_in=en_out=PARK_ADDR, bank_in=bank_out).
- IDLE, arbitration:
  - Eligible req = req of a client whose done is not high this cycle (done-cycle masking; the client must drop req by the cycle after done).
  - One eligible: grant it. Both eligible: grant the one that is not last_served.
  - On grant, at the clock edge: latch op/src/dst/wdata into the command register, set owner, update last_served, go to EX1.
- EX1 by op:
  - READ: en_out=src, en_in=src, bank_in=bank_out; capture result=bank_out. Finish.
  - WRITE: en_in=dst, bank_in=wdata, en_out=dst. Finish.
  - MOVE: en_out=src, en_in=dst, bank_in=bank_out. Finish.
  - SWAP: en_out=src, en_in=src, bank_in=bank_out; tmp<=bank_out; result<=bank_out. Go to EX2.
- EX2 (SWAP only): en_out=dst, en_in=src, bank_in=bank_out. Go to EX3.
- EX3 (SWAP only): en_out=dst, en_in=dst, bank_in=tmp. Finish.
- Finish means: at the edge, set owner's done=1 for exactly one cycle, load owner's rdata with result (READ and SWAP only; unchanged for WRITE and MOVE), go to IDLE.
- Latency from req sampled in IDLE at cycle N to done high:
  - N+2 for READ, WRITE and MOVE.
  - N+4 for SWAP.
  - Back-to-back throughput: one 1-cycle op per 2 cycles.
- The next grant can occur in the done cycle; the other client's pending req wins it.
- Boundary cases:
  - MOVE or SWAP with src==dst leaves the register unchanged.
  - SWAP rdata = old src.
  - WRITE to PARK_ADDR is legal.
  - A client dropping req before done is illegal; the command is already latched, so the op still completes and done still pulses.
  - req in a non-IDLE state is ignored until IDLE.
  - RESET mid-op aborts immediately: no done; partial SWAP results are undefined (the bank is also cleared by the same reset).
- Both done outputs are never high in the same cycle.

Test Plan:
- Reset, then reqA WRITE dst=3 wdata=8'hA5; 2 cycles later reqA READ src=3 -> doneA pulses 2 cycles after each sampled req; rdataA=8'hA5; all other registers read 0.
- Idle for 20 cycles after writing r0=8'h3C (PARK_ADDR) -> r0 still 8'h3C; bank_en_in=bank_en_out=0 throughout; busy=0.
- r2=8'h11, r5=8'h22, reqB SWAP src=2 dst=5 -> doneB at N+4; rdataB=8'h11; afterwards r2=8'h22, r5=8'h11.
- reqA and reqB both held with WRITEs (r1=8'h01, r1=8'h02) from reset -> A served first, B next; doneA and doneB never coincide; final r1=8'h02. Repeat with both held continuously -> grants alternate A, B, A, B.
- MOVE src=4 dst=6 with r4=8'h7E -> r6=8'h7E, r4 unchanged, rdataA unchanged.
- Assert RESET during EX2 of a SWAP -> no done pulse; state IDLE; rdata=0; busy=0 immediately; next req is serviced normally.
